dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - port 0: core memory stage (load/store).
  - port 1: debug/loader port, used for program/data preload and inspection.
- Sits between the memory stage and the data memory. It drives the memory address, write enable and write data, and routes read data back to the granted requester.
- Core has default priority. A starvation counter guarantees the debug port forward progress. The core stalls only when it loses arbitration.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory between the core memory stage (port 0)
//   and the debug/loader port (port 1). The core has default priority. A
//   starvation counter hands priority to the debug port once it has waited
//   STARVE_LIMIT consecutive cycles. Every access completes in the cycle in
//   which it is granted.
//
// Optional feature macro: DMEM_ARB_PERF_EN
//   When defined, adds o_conflict_cnt, a saturating 32-bit count of the cycles
//   in which both ports request.
//
// Ports
//   i_clk, i_arst        clock, asynchronous active-high reset
//   i_core_*             core request (req/we/addr/wdata)
//   o_core_gnt/rdata     core grant and read data (rdata is 0 when not granted)
//   o_core_stall         i_core_req & ~o_core_gnt
//   i_dbg_*              debug request (req/we/addr/wdata)
//   o_dbg_gnt/rdata      debug grant and read data (rdata is 0 when not granted)
//   o_mem_*              memory address/we/wdata, driven from the granted port
//   i_mem_rdata          combinational memory read data
//   o_conflict_cnt       (DMEM_ARB_PERF_EN only) contention cycle count
//
// State table
//   CORE_PRI | core wins a conflict; debug is granted only when the core is idle
//   DBG_PRI  | debug wins a conflict; core is granted only when debug is idle
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int MEM_ADDR_W   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic                  o_core_gnt,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic                  o_core_stall,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic                  o_dbg_gnt,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_mem_we,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           o_conflict_cnt
`endif
);

  typedef enum logic {
    CORE_PRI = 1'b0,
    DBG_PRI  = 1'b1
  } state_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       core_gnt, dbg_gnt;

  // Only the low address bits reach the memory; the rest are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_core_addr[ADDR_WIDTH-1:MEM_ADDR_W],
                              i_dbg_addr[ADDR_WIDTH-1:MEM_ADDR_W]};

  // Grants are gated by reset directly, so they drop the moment reset asserts
  // rather than waiting for the flops to clear.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!i_arst) begin
      if (state_q == CORE_PRI) begin
        core_gnt = i_core_req;
        dbg_gnt  = i_dbg_req & ~i_core_req;
      end else begin
        dbg_gnt  = i_dbg_req;
        core_gnt = i_core_req & ~i_dbg_req;
      end
    end
  end

  always_comb begin
    wait_cnt_d = 8'd0;
    if (i_dbg_req && !dbg_gnt) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end

    state_d = state_q;
    case (state_q)
      CORE_PRI: if (wait_cnt_d == LIMIT) state_d = DBG_PRI;
      DBG_PRI:  if (dbg_gnt || !i_dbg_req) state_d = CORE_PRI;
      default:  state_d = CORE_PRI;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q    <= CORE_PRI;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (core_gnt) begin
      o_mem_we    = i_core_we;
      o_mem_addr  = i_core_addr[MEM_ADDR_W-1:0];
      o_mem_wdata = i_core_wdata;
    end else if (dbg_gnt) begin
      o_mem_we    = i_dbg_we;
      o_mem_addr  = i_dbg_addr[MEM_ADDR_W-1:0];
      o_mem_wdata = i_dbg_wdata;
    end
  end

  assign o_core_gnt   = core_gnt;
  assign o_dbg_gnt    = dbg_gnt;
  assign o_core_stall = i_core_req & ~core_gnt;
  assign o_core_rdata = core_gnt ? i_mem_rdata : '0;
  assign o_dbg_rdata  = dbg_gnt  ? i_mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      conflict_cnt_q <= 32'd0;
    end else if (i_core_req && i_dbg_req && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign o_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        arst;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [63:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_gnt, core_stall, dbg_gnt, mem_we;
  logic [63:0] core_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt;
`endif

  logic [63:0] mem     [0:1023] = '{default: 64'd0};
  logic [63:0] ref_mem [0:1023] = '{default: 64'd0};
  int          waited  = 0;
  logic [31:0] ref_conf = 32'd0;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_ADDR_W(10), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
    .o_core_gnt(core_gnt), .o_core_rdata(core_rdata), .o_core_stall(core_stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rdata(dbg_rdata),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .o_conflict_cnt(conflict_cnt)
`endif
  );

  // Single-port memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic        c_req; logic c_we; logic [63:0] c_addr; logic [63:0] c_wd;
    logic        d_req; logic d_we; logic [63:0] d_addr; logic [63:0] d_wd;
    logic        e_cg;  logic e_dg; logic e_stall; logic e_we;
    logic [9:0]  e_addr; logic [63:0] e_wd; logic [63:0] e_crd; logic [63:0] e_drd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                       input logic dr, input logic dw, input logic [63:0] da, input logic [63:0] dd);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dbg_req  = dr; dbg_we  = dw; dbg_addr  = da; dbg_wdata  = dd;
  endtask

  task automatic mid();
    #5;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Reference: the debug port wins a conflict once it has been refused LIMIT
  // cycles in a row; otherwise the core wins. Also checks data routing.
  task automatic model_check(input string tag);
    logic        ec, ed, ewe;
    logic [9:0]  ea;
    logic [63:0] ewd, ecrd, edrd;
    if (arst) begin
      waited   = 0;
      ref_conf = 32'd0;
    end
    ec = !arst && core_req && (!dbg_req || waited < LIMIT);
    ed = !arst && dbg_req && !ec;
    ewe = 1'b0; ea = 10'd0; ewd = 64'd0; ecrd = 64'd0; edrd = 64'd0;
    if (ec) begin
      ewe = core_we; ea = core_addr[9:0]; ewd = core_wdata; ecrd = ref_mem[ea];
    end else if (ed) begin
      ewe = dbg_we; ea = dbg_addr[9:0]; ewd = dbg_wdata; edrd = ref_mem[ea];
    end
    chk({tag, ".core_gnt"},   {63'd0, core_gnt},   {63'd0, ec});
    chk({tag, ".dbg_gnt"},    {63'd0, dbg_gnt},    {63'd0, ed});
    chk({tag, ".core_stall"}, {63'd0, core_stall}, {63'd0, core_req & ~ec});
    chk({tag, ".mem_we"},     {63'd0, mem_we},     {63'd0, ewe});
    chk({tag, ".mem_addr"},   {54'd0, mem_addr},   {54'd0, ea});
    chk({tag, ".mem_wdata"},  mem_wdata,  ewd);
    chk({tag, ".core_rdata"}, core_rdata, ecrd);
    chk({tag, ".dbg_rdata"},  dbg_rdata,  edrd);
`ifdef DMEM_ARB_PERF_EN
    chk({tag, ".conflict"},   {32'd0, conflict_cnt}, {32'd0, ref_conf});
`endif
    if (!arst) begin
      if (ewe) ref_mem[ea] = ewd;
      if (dbg_req && !ed) waited = (waited < 255) ? waited + 1 : 255;
      else                waited = 0;
      if (core_req && dbg_req && ref_conf != 32'hFFFF_FFFF) ref_conf = ref_conf + 32'd1;
    end
  endtask

  task automatic both_cycles(input int n, input string tag, output logic [7:0] cpat, output logic [7:0] dpat);
    cpat = 8'd0; dpat = 8'd0;
    for (int i = 0; i < n; i++) begin
      mid();
      cpat[i] = core_gnt;
      dpat[i] = dbg_gnt;
      model_check(tag);
      adv();
    end
  endtask

  initial begin
    logic [7:0] cp, dp;

    vecs[0]  = '{0,0,64'h0,64'h0,          1,1,64'h18,64'hDEAD_BEEF, 0,1,0,1,10'h18,64'hDEAD_BEEF,64'h0,64'h0};
    vecs[1]  = '{1,0,64'hFF00_0000_0000_0018,64'h0, 0,0,64'h0,64'h0, 1,0,0,0,10'h18,64'h0,64'hDEAD_BEEF,64'h0};
    vecs[2]  = '{0,0,64'h0,64'h0,          1,1,64'h20,64'h1234,      0,1,0,1,10'h20,64'h1234,64'h0,64'h0};
    vecs[3]  = '{1,0,64'h20,64'h0,         0,0,64'h0,64'h0,          1,0,0,0,10'h20,64'h0,64'h1234,64'h0};
    vecs[4]  = '{0,0,64'h0,64'h0,          0,0,64'h0,64'h0,          0,0,0,0,10'h0,64'h0,64'h0,64'h0};
    for (int i = 5; i <= 8; i++)
      vecs[i] = '{1,0,64'h18,64'h0,        1,0,64'h20,64'h0,         1,0,0,0,10'h18,64'h0,64'hDEAD_BEEF,64'h0};
    vecs[9]  = '{1,0,64'h18,64'h0,         1,0,64'h20,64'h0,         0,1,1,0,10'h20,64'h0,64'h0,64'h1234};
    vecs[10] = '{1,0,64'h18,64'h0,         0,0,64'h20,64'h0,         1,0,0,0,10'h18,64'h0,64'hDEAD_BEEF,64'h0};
    vecs[11] = '{0,0,64'h0,64'h0,          0,0,64'h0,64'h0,          0,0,0,0,10'h0,64'h0,64'h0,64'h0};

    // Reset state, with the core requesting so the stall passthrough is visible.
    arst = 1'b1;
    drive(1, 1, 64'h5, 64'h77, 1, 1, 64'h6, 64'h88);
    #3;
    model_check("reset");
    chk("reset.stall_is_req", {63'd0, core_stall}, 64'd1);
    drive(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
    adv();
    arst = 1'b0;

    // Directed table: loader preload, core reads back, contention 4:1.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wd,
            vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wd);
      mid();
      chk($sformatf("vec%0d.core_gnt", i),   {63'd0, core_gnt},   {63'd0, vecs[i].e_cg});
      chk($sformatf("vec%0d.dbg_gnt", i),    {63'd0, dbg_gnt},    {63'd0, vecs[i].e_dg});
      chk($sformatf("vec%0d.core_stall", i), {63'd0, core_stall}, {63'd0, vecs[i].e_stall});
      chk($sformatf("vec%0d.mem_we", i),     {63'd0, mem_we},     {63'd0, vecs[i].e_we});
      chk($sformatf("vec%0d.mem_addr", i),   {54'd0, mem_addr},   {54'd0, vecs[i].e_addr});
      chk($sformatf("vec%0d.mem_wdata", i),  mem_wdata,  vecs[i].e_wd);
      chk($sformatf("vec%0d.core_rdata", i), core_rdata, vecs[i].e_crd);
      chk($sformatf("vec%0d.dbg_rdata", i),  dbg_rdata,  vecs[i].e_drd);
      model_check($sformatf("vec%0d.model", i));
      adv();
    end

    // Debug withdraws after two refused cycles: its wait must start over.
    drive(1, 0, 64'h18, 64'h0, 1, 0, 64'h20, 64'h0);
    both_cycles(2, "wd.pre", cp, dp);
    chk("wd.pre.no_dbg", {56'd0, dp}, 64'd0);
    drive(1, 0, 64'h18, 64'h0, 0, 0, 64'h20, 64'h0);
    mid(); chk("wd.drop.dbg_gnt", {63'd0, dbg_gnt}, 64'd0); model_check("wd.drop"); adv();
    drive(1, 0, 64'h18, 64'h0, 1, 0, 64'h20, 64'h0);
    both_cycles(5, "wd.post", cp, dp);
    chk("wd.post.core_pat", {56'd0, cp}, 64'h0F);
    chk("wd.post.dbg_pat",  {56'd0, dp}, 64'h10);
    drive(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
    mid(); model_check("wd.idle"); adv();

    // Reset mid-contention at wait count 3 discards the pending priority.
    drive(1, 1, 64'h30, 64'h55, 1, 0, 64'h20, 64'h0);
    both_cycles(3, "rst.pre", cp, dp);
    chk("rst.pre.core_pat", {56'd0, cp}, 64'h07);
    #2;
    arst = 1'b1;
    #3;
    chk("rst.mid.core_gnt", {63'd0, core_gnt}, 64'd0);
    chk("rst.mid.dbg_gnt",  {63'd0, dbg_gnt},  64'd0);
    chk("rst.mid.mem_we",   {63'd0, mem_we},   64'd0);
    chk("rst.mid.stall",    {63'd0, core_stall}, 64'd1);
    model_check("rst.mid");
    adv();
    arst = 1'b0;
    both_cycles(5, "rst.post", cp, dp);
    chk("rst.post.core_pat", {56'd0, cp}, 64'h0F);
    chk("rst.post.dbg_pat",  {56'd0, dp}, 64'h10);

`ifdef DMEM_ARB_PERF_EN
    arst = 1'b1; #1; model_check("perf.rst"); adv(); arst = 1'b0;
    drive(1, 0, 64'h18, 64'h0, 1, 0, 64'h20, 64'h0);
    both_cycles(8, "perf.a", cp, dp);
    both_cycles(2, "perf.b", cp, dp);
    drive(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
    mid();
    chk("perf.count10", {32'd0, conflict_cnt}, 64'd10);
    arst = 1'b1; #1;
    chk("perf.reset0", {32'd0, conflict_cnt}, 64'd0);
    model_check("perf.rst2");
    adv(); arst = 1'b0;
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            {32'($urandom), 22'($urandom), 10'($urandom_range(0, 15))}, {32'($urandom), 32'($urandom)},
            $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            {32'($urandom), 22'($urandom), 10'($urandom_range(0, 15))}, {32'($urandom), 32'($urandom)});
      mid();
      model_check($sformatf("rnd%0d", i));
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
